// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU (A) and load (B) writeback.
// Clears all registers after reset, then grants A by priority with a starvation guard for B.
`default_nettype none

module regfile_write_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int ZERO_REG     = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] rf_D,
    output logic [ADDR_WIDTH-1:0] rf_DA,
    output logic                  rf_W,
    output logic                  init_done
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]      STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = ADDR_WIDTH'(ZERO_REG);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q,  init_cnt_d;
    logic [CNT_W-1:0]        starve_q,    starve_d;
    logic                    rf_w_q,      rf_w_d;
    logic [ADDR_WIDTH-1:0]   rf_da_q,     rf_da_d;
    logic [DATA_WIDTH-1:0]   rf_d_q,      rf_d_d;
    logic                    init_done_q, init_done_d;

    logic                  run;
    logic                  force_b;
    logic                  a_xfer;
    logic                  b_xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Ready is gated by reset so no handshake can coincide with a reset edge.
    assign run      = reset && (state_q == ST_RUN);
    assign force_b  = (starve_q == STARVE_MAX);
    assign a_ready  = run && !(b_valid && force_b);
    assign b_ready  = run && (!a_valid || force_b);
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;
    assign sel_addr = a_xfer ? a_addr : b_addr;
    assign sel_data = a_xfer ? a_data : b_data;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        starve_d    = starve_q;
        rf_w_d      = 1'b0;
        rf_da_d     = rf_da_q;
        rf_d_d      = rf_d_q;
        init_done_d = init_done_q;

        case (state_q)
            ST_INIT: begin
                rf_w_d     = 1'b1;
                rf_da_d    = init_cnt_q;
                rf_d_d     = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if ((a_xfer || b_xfer) && (sel_addr != ZERO_ADDR)) begin
                    rf_w_d  = 1'b1;
                    rf_da_d = sel_addr;
                    rf_d_d  = sel_data;
                end
                if (a_xfer && b_valid) begin
                    if (!force_b) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (b_xfer || !b_valid) begin
                    starve_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            starve_q    <= '0;
            rf_w_q      <= 1'b0;
            rf_da_q     <= '0;
            rf_d_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            starve_q    <= starve_d;
            rf_w_q      <= rf_w_d;
            rf_da_q     <= rf_da_d;
            rf_d_q      <= rf_d_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_W      = rf_w_q;
    assign rf_DA     = rf_da_q;
    assign rf_D      = rf_d_q;
    assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed bench with an expected-write queue and a behavioural register file.
`default_nettype none

module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic [63:0] rf_D;
    logic [4:0]  rf_DA;
    logic        rf_W;
    logic        init_done;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] mem[32];
    int          n_tests = 0;
    int          n_fail  = 0;

    regfile_write_arbiter #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .STARVE_LIMIT(4), .ZERO_REG(31)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_D(rf_D), .rf_DA(rf_DA), .rf_W(rf_W), .init_done(init_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [4:0] addr, input logic [63:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Register file model: commits whatever the write port presents at each rising edge.
    always @(posedge clock) begin
        if (rf_W === 1'b1) mem[rf_DA] <= rf_D;
    end

    always @(negedge clock) begin
        if (rf_W === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {59'd0, rf_DA}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {59'd0, rf_DA}, {59'd0, e.addr});
                chk("wr_data", rf_D, e.data);
            end
        end
    end

    initial begin
        int ai;
        int bi;
        logic exp_b;
        for (int i = 0; i < 32; i++) mem[i] = 'x;
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;

        step();
        step();
        chk("reset_rf_W", {63'd0, rf_W}, 64'd0);
        chk("reset_init_done", {63'd0, init_done}, 64'd0);
        chk("reset_a_ready", {63'd0, a_ready}, 64'd0);

        // Clear sequence: readies stay low even with both requesters pending.
        reset = 1'b1;
        for (int i = 0; i < 32; i++) push(5'(i), 64'd0);
        a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd3; b_addr = 5'd4;
        for (int i = 0; i < 32; i++) begin
            chk("init_a_ready", {63'd0, a_ready}, 64'd0);
            chk("init_b_ready", {63'd0, b_ready}, 64'd0);
            chk("init_done_low", {63'd0, init_done}, 64'd0);
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("init_done_high", {63'd0, init_done}, 64'd1);
        chk("init_last_da", {59'd0, rf_DA}, 64'd31);

        // Single A write.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 64'hDEADBEEF_CAFEF00D;
        #1;
        chk("a_single_ready", {63'd0, a_ready}, 64'd1);
        push(5'd5, 64'hDEADBEEF_CAFEF00D);
        step();
        a_valid = 1'b0;
        chk("a_single_W", {63'd0, rf_W}, 64'd1);
        step();
        chk("a_single_W_off", {63'd0, rf_W}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            if (i != 5) chk("init_reg_zero", mem[i], 64'd0);
        end
        chk("reg5_value", mem[5], 64'hDEADBEEF_CAFEF00D);

        // Both requesters continuously valid: A,A,A,A,B repeating.
        ai = 0; bi = 0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 5'd8;  a_data = 64'hA000_0000_0000_0000;
        b_addr = 5'd20; b_data = 64'hB000_0000_0000_0000;
        for (int k = 0; k < 10; k++) begin
            exp_b = ((k % 5) == 4);
            #1;
            chk("starve_a_ready", {63'd0, a_ready}, {63'd0, !exp_b});
            chk("starve_b_ready", {63'd0, b_ready}, {63'd0, exp_b});
            if (exp_b) push(b_addr, b_data);
            else       push(a_addr, a_data);
            step();
            if (exp_b) begin
                bi++;
                b_addr = 5'(20 + bi);
                b_data = 64'hB000_0000_0000_0000 + 64'(bi);
            end else begin
                ai++;
                a_addr = 5'(8 + ai);
                a_data = 64'hA000_0000_0000_0000 + 64'(ai);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        step();
        chk("reg21_after_starve", mem[21], 64'hB000_0000_0000_0001);

        // B write to the zero register completes but is not emitted.
        b_valid = 1'b1; b_addr = 5'd31; b_data = 64'h1;
        #1;
        chk("zero_b_ready", {63'd0, b_ready}, 64'd1);
        step();
        b_valid = 1'b0;
        chk("zero_rf_W", {63'd0, rf_W}, 64'd0);
        step();
        chk("reg31_zero", mem[31], 64'd0);

        // B alone for six cycles: granted every cycle, writes in order.
        b_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            b_addr = 5'(k);
            b_data = 64'h1111_0000_0000_0000 + 64'(k);
            #1;
            chk("b_alone_ready", {63'd0, b_ready}, 64'd1);
            push(b_addr, b_data);
            step();
        end
        b_valid = 1'b0;
        step();
        step();
        chk("reg6_value", mem[6], 64'h1111_0000_0000_0006);
        chk("queue_drained_run", 64'(exp_q.size()), 64'd0);

        // A request coinciding with reset: no handshake, no write, INIT restarts at DA=0.
        a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h7777_7777_7777_7777;
        reset = 1'b0;
        #1;
        chk("rst_a_ready", {63'd0, a_ready}, 64'd0);
        chk("rst_b_ready", {63'd0, b_ready}, 64'd0);
        step();
        a_valid = 1'b0;
        chk("rst_rf_W", {63'd0, rf_W}, 64'd0);
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) push(5'(i), 64'd0);
        step();
        chk("reinit_da0", {59'd0, rf_DA}, 64'd0);
        for (int i = 0; i < 31; i++) step();
        chk("reinit_done", {63'd0, init_done}, 64'd1);
        step();
        step();
        chk("reg7_zero", mem[7], 64'd0);
        chk("queue_drained_end", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port (D, DA, W) of the 32x64 register file between two writeback requesters. Requester A is the ALU writeback path; requester B is the memory-load writeback path. After reset, a sequencer clears all 32 registers to zero before any requester is granted. The block then arbitrates one write per cycle, giving A fixed priority, with a starvation guard for B, and silently drops writes to the zero register.

Parameters:
DATA_WIDTH, 64, register data width
ADDR_WIDTH, 5, register address width (32 registers)
STARVE_LIMIT, 4, number of consecutive A grants while B is waiting before B is forced through
ZERO_REG, 31, register index whose writes are discarded in RUN

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
a_valid  input  1  requester A has a write pending
a_ready  output  1  A transfer accepted this cycle
a_addr  input  ADDR_WIDTH  A destination register
a_data  input  DATA_WIDTH  A write data
b_valid  input  1  requester B has a write pending
b_ready  output  1  B transfer accepted this cycle
b_addr  input  ADDR_WIDTH  B destination register
b_data  input  DATA_WIDTH  B write data
rf_D  output  DATA_WIDTH  to register file D
rf_DA  output  ADDR_WIDTH  to register file DA
rf_W  output  1  to register file W
init_done  output  1  high once the clear sequence has completed

Behaviour:
- Reset (reset==0 at an edge): state=INIT, init_cnt=0, starve_cnt=0, rf_W=0, rf_DA=0, rf_D=0, init_done=0. a_ready and b_ready are forced combinationally to 0 whenever reset==0, so no handshake can coincide with reset.
- rf_D, rf_DA and rf_W are registered. A handshake at edge N drives rf_* during cycle N..N+1, and the register file commits the write at edge N+1.
- INIT: a_ready=b_ready=0. At each edge: rf_W<=1, rf_DA<=init_cnt, rf_D<=0, init_cnt<=init_cnt+1.
- INIT exit: at the edge where init_cnt==31, the block emits DA=31, sets state<=RUN and init_done<=1. The result is exactly 32 consecutive write cycles, DA 0..31, all with D=0.
- RUN handshake: a transfer occurs on an edge where valid&&ready. The ready equations are:
  - force_b = (starve_cnt==STARVE_LIMIT)
  - a_ready = RUN && !(b_valid && force_b)
  - b_ready = RUN && (!a_valid || force_b)
  - Ready never depends on its own valid, so there is no combinational loop. At most one transfer occurs per edge.
- RUN output update:
  - On a transfer whose addr!=ZERO_REG: rf_W<=1, rf_DA<=addr, rf_D<=data.
  - On a transfer whose addr==ZERO_REG: the handshake completes, but rf_W<=0.
  - With no transfer: rf_W<=0, and rf_DA/rf_D hold their values.
- starve_cnt update, applied in RUN at each edge:
  - If A transfers while b_valid=1, increment (saturating at STARVE_LIMIT).
  - If B transfers, or b_valid=0, clear to 0.
  - Otherwise hold.
- Requesters must hold valid, addr and data stable until ready. Deasserting valid without a transfer is permitted and has no side effects.
- init_done stays 1 until the next reset. State never returns to INIT except via reset.
- Reset mid-RUN: any write registered on rf_* but not yet committed is cancelled, because rf_W<=0 at the reset edge. The next INIT restarts at DA=0.
- Reset mid-INIT: init_cnt restarts at 0.

Test Plan:
- Release reset at cycle 0 -> rf_W=1 for 32 consecutive cycles with rf_DA=0,1,...,31 and rf_D=0. a_ready=b_ready=0 throughout. init_done=1 from the cycle after the DA=31 write. All R00..R31 read 0.
- After init, a_valid=1, a_addr=5, a_data=64'hDEADBEEF_CAFEF00D for one handshake -> next cycle rf_W=1, rf_DA=5, rf_D=64'hDEADBEEF_CAFEF00D. The following cycle rf_W=0, and reading register 5 returns that value.
- a_valid and b_valid held at 1 continuously, distinct addrs, STARVE_LIMIT=4 -> grant sequence A,A,A,A,B,A,A,A,A,B; starve_cnt goes 1,2,3,4,0,... Never both readies high with both valids.
- b_valid=1, b_addr=31, b_data=64'h1, a_valid=0 -> b_ready=1 and the handshake completes; rf_W stays 0; register 31 still reads 0.
- a_valid=0, b_valid=1 for 6 cycles with b_addr=1..6 -> b_ready=1 every cycle; six writes appear on rf_* in order; starve_cnt remains 0.
- In RUN, a_valid=1 with a_addr=7, then reset=0 on the same edge -> a_ready=0 during the reset cycle; rf_W=0 after the edge; register 7 is not written. On reset release, INIT restarts with rf_DA=0.
